// File: rtl/rtc_alarm_ctrl.sv
// User-facing controller for the rtc: time/alarm editing plus the alarm
// ring / snooze / stop sequence driving the buzzer.
module rtc_alarm_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 30,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       alarm_hit,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic       set_load,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic       buzzer,
    output logic [2:0] mode
);
    localparam int CW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(MAX_SNOOZE + 1);

    typedef enum logic [2:0] {M_RUN, M_SET_HR, M_SET_MIN, M_SET_AHR, M_SET_AMIN} mode_t;
    typedef enum logic [1:0] {R_IDLE, R_RING, R_SNOOZE} ring_t;

    mode_t         mode_q;
    ring_t         rstate;
    logic [4:0]    edit_hr, user_hr, snz_hr;
    logic [5:0]    edit_min, user_min, snz_min;
    logic          hit_q;
    logic [5:0]    sec_q;
    logic [CW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;

    function automatic logic [4:0] inc_hr(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    // Increment lands before a same-cycle mode advance, so set_load sees it.
    logic [4:0] edit_hr_nx;
    logic [5:0] edit_min_nx;
    assign edit_hr_nx  = (mode_q == M_SET_HR  && btn_inc) ? inc_hr(edit_hr)   : edit_hr;
    assign edit_min_nx = (mode_q == M_SET_MIN && btn_inc) ? inc_min(edit_min) : edit_min;

    logic       trigger, alarm_off, timeout, min_wrap;
    logic [6:0] min_sum;
    logic [4:0] snz_hr_nx;
    logic [5:0] snz_min_nx;

    assign trigger   = alarm_hit && !hit_q && (mode_q == M_RUN) && alarm_en;
    assign alarm_off = btn_alarm && (mode_q == M_RUN) && alarm_en;
    assign timeout   = (ring_cnt >= CW'(RING_SEC));

    assign min_sum    = {1'b0, min} + 7'(SNOOZE_MIN);
    assign min_wrap   = (min_sum > 7'd59);
    assign snz_min_nx = min_wrap ? 6'(min_sum - 7'd60) : min_sum[5:0];
    assign snz_hr_nx  = min_wrap ? inc_hr(hour) : hour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= M_RUN;
            edit_hr  <= '0;
            edit_min <= '0;
            user_hr  <= '0;
            user_min <= '0;
            alarm_en <= 1'b0;
            set_load <= 1'b0;
            set_hour <= '0;
            set_min  <= '0;
            hit_q    <= 1'b0;
            sec_q    <= '0;
        end else begin
            hit_q    <= alarm_hit;
            sec_q    <= sec;
            set_load <= 1'b0;
            edit_hr  <= edit_hr_nx;
            edit_min <= edit_min_nx;
            if (mode_q == M_SET_AHR && btn_inc)  user_hr  <= inc_hr(user_hr);
            if (mode_q == M_SET_AMIN && btn_inc) user_min <= inc_min(user_min);
            if (mode_q == M_RUN && btn_alarm)    alarm_en <= ~alarm_en;
            if (btn_mode) begin
                case (mode_q)
                    M_RUN: begin
                        edit_hr  <= hour;
                        edit_min <= min;
                        mode_q   <= M_SET_HR;
                    end
                    M_SET_HR:  mode_q <= M_SET_MIN;
                    M_SET_MIN: begin
                        mode_q   <= M_SET_AHR;
                        set_load <= 1'b1;
                        set_hour <= edit_hr_nx;
                        set_min  <= edit_min_nx;
                    end
                    M_SET_AHR: mode_q <= M_SET_AMIN;
                    default:   mode_q <= M_RUN;
                endcase
            end
        end
    end

    // Disabling the alarm overrides everything else in the ring sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate   <= R_IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_hr   <= '0;
            snz_min  <= '0;
        end else if (alarm_off) begin
            rstate <= R_IDLE;
        end else begin
            case (rstate)
                R_IDLE: if (trigger) begin
                    rstate   <= R_RING;
                    ring_cnt <= '0;
                    snz_cnt  <= '0;
                end
                R_RING: begin
                    if (btn_stop) begin
                        rstate <= R_IDLE;
                    end else if (btn_snooze || timeout) begin
                        if (snz_cnt < SW'(MAX_SNOOZE)) begin
                            rstate  <= R_SNOOZE;
                            snz_cnt <= snz_cnt + SW'(1);
                            snz_hr  <= snz_hr_nx;
                            snz_min <= snz_min_nx;
                        end else begin
                            rstate <= R_IDLE;
                        end
                    end else if (sec != sec_q) begin
                        ring_cnt <= ring_cnt + CW'(1);
                    end
                end
                R_SNOOZE: begin
                    if (btn_stop) begin
                        rstate <= R_IDLE;
                    end else if (trigger) begin
                        rstate   <= R_RING;
                        ring_cnt <= '0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign buzzer    = (rstate == R_RING);
    assign alarm_hr  = {1'b0, (rstate == R_SNOOZE) ? snz_hr : user_hr};
    assign alarm_min = (rstate == R_SNOOZE) ? snz_min : user_min;
    assign mode      = mode_q;
endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Bench for rtc_alarm_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the alarm clock.
module tb_rtc_alarm_ctrl;
    localparam int SNOOZE_MIN = 5;
    localparam int RING_SEC   = 30;
    localparam int MAX_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       alarm_hit, btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop;
    logic       set_load, alarm_en, buzzer;
    logic [4:0] set_hour;
    logic [5:0] set_min, alarm_hr, alarm_min;
    logic [2:0] mode;

    always #5 clk = ~clk;

    rtc_alarm_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hour(hour), .alarm_hit(alarm_hit),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop), .set_load(set_load),
        .set_hour(set_hour), .set_min(set_min), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .alarm_en(alarm_en), .buzzer(buzzer), .mode(mode)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: alarm clock state in plain numbers; snooze target kept as minutes of day.
    int m_mode, m_ehr, m_emin, m_ahr, m_amin, m_lhr, m_lmin;
    int m_state;   // 0 idle, 1 ringing, 2 snoozed
    int m_tgt, m_heard, m_snoozes, m_sec_prev;
    bit m_en, m_load, m_hit_prev;

    task automatic model_reset();
        m_mode = 0; m_ehr = 0; m_emin = 0; m_ahr = 0; m_amin = 0; m_lhr = 0; m_lmin = 0;
        m_state = 0; m_tgt = 0; m_heard = 0; m_snoozes = 0; m_sec_prev = 0;
        m_en = 0; m_load = 0; m_hit_prev = 0;
    endtask

    task automatic model_step();
        bit trig, off;
        int ns;
        trig = alarm_hit && !m_hit_prev && m_mode == 0 && m_en;
        off  = btn_alarm && m_mode == 0 && m_en;
        ns = m_state;
        if (off) ns = 0;
        else if (m_state == 0) begin
            if (trig) begin ns = 1; m_heard = 0; m_snoozes = 0; end
        end else if (m_state == 1) begin
            if (btn_stop) ns = 0;
            else if (btn_snooze || m_heard >= RING_SEC) begin
                if (m_snoozes < MAX_SNOOZE) begin
                    ns = 2; m_snoozes++;
                    m_tgt = (int'(hour) * 60 + int'(min) + SNOOZE_MIN) % 1440;
                end else ns = 0;
            end else if (sec != 6'(m_sec_prev)) m_heard++;
        end else begin
            if (btn_stop) ns = 0;
            else if (trig) begin ns = 1; m_heard = 0; end
        end
        m_state = ns;
        m_load = 0;
        if (btn_inc) begin
            case (m_mode)
                1: m_ehr  = (m_ehr + 1) % 24;
                2: m_emin = (m_emin + 1) % 60;
                3: m_ahr  = (m_ahr + 1) % 24;
                4: m_amin = (m_amin + 1) % 60;
                default: ;
            endcase
        end
        if (btn_alarm && m_mode == 0) m_en = !m_en;
        if (btn_mode) begin
            if (m_mode == 0) begin m_ehr = hour; m_emin = min; end
            if (m_mode == 2) begin m_load = 1; m_lhr = m_ehr; m_lmin = m_emin; end
            m_mode = (m_mode + 1) % 5;
        end
        m_hit_prev = alarm_hit;
        m_sec_prev = sec;
    endtask

    function automatic logic [28:0] model_out();
        int h, m;
        if (m_state == 2) begin h = m_tgt / 60; m = m_tgt % 60; end
        else begin h = m_ahr; m = m_amin; end
        return {m_load, 5'(m_lhr), 6'(m_lmin), 6'(h), 6'(m), m_en, (m_state == 1), 3'(m_mode)};
    endfunction

    logic [28:0] dut_vec;
    assign dut_vec = {set_load, set_hour, set_min, alarm_hr, alarm_min, alarm_en, buzzer, mode};

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        btn_mode = 0; btn_inc = 0; btn_alarm = 0; btn_snooze = 0; btn_stop = 0;
    endtask

    task automatic test_reset();
        rst = 1; sec = 0; min = 0; hour = 0; alarm_hit = 0;
        btn_mode = 0; btn_inc = 0; btn_alarm = 0; btn_snooze = 0; btn_stop = 0;
        cyc(); cyc();
        n_chk++; if (dut_vec !== 29'd0) $display("FAIL reset_state: got %h want 0", dut_vec); else n_pass++;
        rst = 0;
        cyc();
        n_chk++; if (dut_vec !== model_out()) $display("FAIL reset_release: got %h want %h", dut_vec, model_out()); else n_pass++;
    endtask

    task automatic test_time_set();
        hour = 9; min = 59;
        btn_mode = 1; cyc();
        n_chk++; if (mode !== 3'd1) $display("FAIL set_enter_hr: mode=%0d want 1", mode); else n_pass++;
        btn_inc = 1; cyc();
        btn_mode = 1; cyc();
        for (int i = 0; i < 21; i++) begin btn_inc = 1; cyc(); end
        btn_mode = 1; cyc();
        n_chk++;
        if (set_load !== 1'b1 || set_hour !== 5'd10 || set_min !== 6'd20 || mode !== 3'd3)
            $display("FAIL set_load_pulse: load=%b %0d:%0d mode=%0d want 1 10:20 mode 3", set_load, set_hour, set_min, mode);
        else n_pass++;
        cyc();
        n_chk++; if (set_load !== 1'b0) $display("FAIL set_load_single: load=%b want 0", set_load); else n_pass++;
        for (int i = 0; i < 10; i++) begin btn_inc = 1; cyc(); end
        btn_mode = 1; cyc();
        for (int i = 0; i < 19; i++) begin btn_inc = 1; cyc(); end
        btn_inc = 1; btn_mode = 1; cyc();   // last increment shares the cycle with mode
        btn_alarm = 1; cyc();
        n_chk++;
        if (alarm_hr !== 6'd10 || alarm_min !== 6'd20 || alarm_en !== 1'b1 || mode !== 3'd0)
            $display("FAIL alarm_set: %0d:%0d en=%b mode=%0d want 10:20 en 1 mode 0", alarm_hr, alarm_min, alarm_en, mode);
        else n_pass++;
        n_chk++; if (dut_vec !== model_out()) $display("FAIL time_set_model: got %h want %h", dut_vec, model_out()); else n_pass++;
    endtask

    task automatic test_alarm_timeout();
        hour = 10; min = 20; sec = 0;
        alarm_hit = 1; cyc();
        n_chk++; if (buzzer !== 1'b1) $display("FAIL ring_start: buzzer=%b want 1", buzzer); else n_pass++;
        for (int i = 1; i < RING_SEC; i++) begin sec = 6'((sec + 1) % 60); cyc(); cyc(); cyc(); end
        alarm_hit = 0;
        n_chk++; if (buzzer !== 1'b1) $display("FAIL ring_before_timeout: buzzer=%b want 1", buzzer); else n_pass++;
        sec = 6'((sec + 1) % 60); cyc(); cyc(); cyc();
        n_chk++;
        if (buzzer !== 1'b0 || alarm_hr !== 6'd10 || alarm_min !== 6'd25)
            $display("FAIL timeout_snooze: buzzer=%b %0d:%0d want 0 10:25", buzzer, alarm_hr, alarm_min);
        else n_pass++;
        n_chk++; if (dut_vec !== model_out()) $display("FAIL timeout_model: got %h want %h", dut_vec, model_out()); else n_pass++;
    endtask

    task automatic test_snooze_wrap();
        hour = 23; min = 58;
        alarm_hit = 1; cyc();
        n_chk++; if (buzzer !== 1'b1) $display("FAIL resnooze_ring: buzzer=%b want 1", buzzer); else n_pass++;
        btn_snooze = 1; cyc();
        n_chk++;
        if (alarm_hr !== 6'd0 || alarm_min !== 6'd3 || buzzer !== 1'b0)
            $display("FAIL snooze_wrap: %0d:%0d buzzer=%b want 0:3 0", alarm_hr, alarm_min, buzzer);
        else n_pass++;
        alarm_hit = 0; cyc(); alarm_hit = 1; cyc();
        btn_snooze = 1; cyc();
        alarm_hit = 0; cyc(); alarm_hit = 1; cyc();
        n_chk++; if (buzzer !== 1'b1) $display("FAIL fourth_ring: buzzer=%b want 1", buzzer); else n_pass++;
        btn_snooze = 1; cyc();
        n_chk++;
        if (buzzer !== 1'b0 || alarm_hr !== 6'd10 || alarm_min !== 6'd20)
            $display("FAIL snooze_limit: buzzer=%b %0d:%0d want 0 10:20", buzzer, alarm_hr, alarm_min);
        else n_pass++;
        alarm_hit = 0; cyc();
    endtask

    task automatic test_stop_priority();
        alarm_hit = 1; cyc();
        btn_snooze = 1; cyc();
        alarm_hit = 0; cyc(); alarm_hit = 1; cyc();
        btn_stop = 1; btn_snooze = 1; cyc();
        n_chk++;
        if (buzzer !== 1'b0 || alarm_hr !== 6'd10 || alarm_min !== 6'd20)
            $display("FAIL stop_priority: buzzer=%b %0d:%0d want 0 10:20", buzzer, alarm_hr, alarm_min);
        else n_pass++;
        n_chk++; if (dut_vec !== model_out()) $display("FAIL stop_model: got %h want %h", dut_vec, model_out()); else n_pass++;
        alarm_hit = 0; cyc();
    endtask

    task automatic test_edit_suppress();
        btn_mode = 1; cyc(); btn_mode = 1; cyc();
        alarm_hit = 1; cyc(); cyc();
        n_chk++;
        if (buzzer !== 1'b0 || mode !== 3'd2) $display("FAIL edit_suppress: buzzer=%b mode=%0d want 0 2", buzzer, mode);
        else n_pass++;
        alarm_hit = 0;
        for (int i = 0; i < 3; i++) begin btn_mode = 1; cyc(); end
        alarm_hit = 1; cyc();
        n_chk++; if (buzzer !== 1'b1) $display("FAIL run_ring: buzzer=%b want 1", buzzer); else n_pass++;
        btn_snooze = 1; cyc();
        btn_alarm = 1; cyc();
        n_chk++;
        if (alarm_en !== 1'b0 || buzzer !== 1'b0 || alarm_hr !== 6'd10 || alarm_min !== 6'd20)
            $display("FAIL disable_in_snooze: en=%b buzzer=%b %0d:%0d want 0 0 10:20", alarm_en, buzzer, alarm_hr, alarm_min);
        else n_pass++;
        alarm_hit = 0; cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            btn_mode   = ($urandom_range(m_mode == 0 ? 39 : 5, 0) == 0);
            btn_inc    = ($urandom_range(5, 0) == 0);
            btn_alarm  = ($urandom_range(24, 0) == 0);
            btn_snooze = ($urandom_range(29, 0) == 0);
            btn_stop   = ($urandom_range(39, 0) == 0);
            if ($urandom_range(7, 0) == 0) alarm_hit = ~alarm_hit;
            if ($urandom_range(1, 0) == 0) sec = 6'((sec + 1) % 60);
            if ($urandom_range(49, 0) == 0) begin
                hour = 5'($urandom_range(23, 0));
                min  = 6'($urandom_range(59, 0));
            end
            cyc();
            n_chk++;
            if (dut_vec !== model_out()) $display("FAIL random_%0d: got %h want %h", i, dut_vec, model_out());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_ring();
        for (int i = 0; i < 5 && m_mode != 0; i++) begin btn_mode = 1; cyc(); end
        if (!m_en) begin btn_alarm = 1; cyc(); end
        alarm_hit = 0; btn_stop = 1; cyc();
        alarm_hit = 1; cyc();
        n_chk++; if (buzzer !== 1'b1) $display("FAIL pre_reset_ring: buzzer=%b want 1", buzzer); else n_pass++;
        #2 rst = 1;
        #1;
        n_chk++;
        if (buzzer !== 1'b0 || alarm_en !== 1'b0 || mode !== 3'd0 || alarm_hr !== 6'd0 || alarm_min !== 6'd0)
            $display("FAIL reset_mid_ring: buzzer=%b en=%b mode=%0d %0d:%0d want all 0", buzzer, alarm_en, mode, alarm_hr, alarm_min);
        else n_pass++;
        cyc(); cyc();
        rst = 0;
        cyc();
        n_chk++; if (dut_vec !== model_out()) $display("FAIL post_reset_model: got %h want %h", dut_vec, model_out()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_time_set();
        test_alarm_timeout();
        test_snooze_wrap();
        test_stop_priority();
        test_edit_suppress();
        test_random();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rtc_alarm_ctrl.md
Name: rtc_alarm_ctrl

Overview:
- User-facing controller for the rtc block: sets time, sets alarm, and sequences the alarm ring/snooze/stop cycle.
- Sits between debounced push-button pulses and the rtc.
- Consumes rtc sec/min/hour and alarm_out.
- Drives rtc time-load, alarm_hr/alarm_min/alarm_en, and the buzzer.

Parameters:
- SNOOZE_MIN, 5, minutes added to the current time on snooze (1..59).
- RING_SEC, 30, seconds of buzzing before automatic timeout to snooze.
- MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze or timeout acts as stop.

Ports:
- clk  in  1  system clock (same clock as rtc)
- rst  in  1  reset, asynchronous, active-high
- sec  in  6  rtc seconds, 0..59
- min  in  6  rtc minutes, 0..59
- hour  in  5  rtc hours, 0..23
- alarm_hit  in  1  rtc alarm_out, level, high while time matches alarm
- btn_mode  in  1  1-cycle pulse, advance edit mode
- btn_inc  in  1  1-cycle pulse, increment field being edited
- btn_alarm  in  1  1-cycle pulse, toggle alarm enable (RUN mode only)
- btn_snooze  in  1  1-cycle pulse, snooze ringing alarm
- btn_stop  in  1  1-cycle pulse, stop ringing alarm
- set_load  out  1  1-cycle strobe: rtc loads set_hour/set_min, sec=0
- set_hour  out  5  time to load
- set_min  out  6  time to load
- alarm_hr  out  6  effective alarm hour to rtc
- alarm_min  out  6  effective alarm minute to rtc
- alarm_en  out  1  alarm enable to rtc
- buzzer  out  1  high while ringing
- mode  out  3  0=RUN 1=SET_HR 2=SET_MIN 3=SET_AHR 4=SET_AMIN

Behaviour:
- Reset (async, rst=1): mode=RUN, ring FSM=IDLE; user alarm=00:00; alarm_en=0; buzzer=0; set_load=0; set_hour/set_min=0; snooze count=0. Reset mid-ring clears buzzer immediately.
- Edit FSM (all transitions on btn_mode):
  - RUN->SET_HR: edit_hr/edit_min load from hour/min.
  - SET_HR->SET_MIN.
  - SET_MIN->SET_AHR: set_load=1 for exactly the next cycle with set_hour=edit_hr, set_min=edit_min.
  - SET_AHR->SET_AMIN->RUN.
- btn_inc in SET_HR: edit_hr 23->0 wrap. In SET_MIN: edit_min 59->0. SET_AHR: user alarm hour 23->0. SET_AMIN: user alarm minute 59->0. Ignored in RUN.
- btn_mode and btn_inc in the same cycle: inc applies to the current field first, then mode advances.
- btn_alarm in RUN toggles alarm_en. Clearing alarm_en while ringing or snoozed forces ring FSM to IDLE, buzzer=0.
- Effective alarm: alarm_hr/alarm_min = snooze target when ring FSM=SNOOZE, else user alarm. Upper bit of alarm_hr is always 0.
- Trigger: a rising edge of alarm_hit (registered previous value) while mode=RUN and alarm_en=1. Ignored in edit modes and while already RING.
- Ring FSM:
  - IDLE->RING on trigger. Buzzer asserts the cycle after the edge; sec counter=0; snooze count=0 when coming from IDLE.
  - RING: each change of sec (sec != registered sec) increments the counter.
  - btn_stop -> IDLE.
  - btn_snooze, or counter reaching RING_SEC:
    - if snooze count < MAX_SNOOZE: go to SNOOZE, count+1, snooze target = current hour:min + SNOOZE_MIN (minute wrap >59 carries hour; hour 23->0).
    - otherwise go to IDLE.
  - btn_stop and btn_snooze in the same cycle: stop wins.
  - SNOOZE: rising alarm_hit (against snooze target) -> RING; count kept. btn_stop -> IDLE, user alarm restored.
- Buzzer = 1 only in RING; latency: state change is visible one cycle after the triggering input.

Test Plan:
- Reset mid-ring: rst asserted during RING -> buzzer=0 same cycle, alarm_en=0, mode=0, alarm 00:00.
- Time set at 10:20: rtc at 09:59, mode, inc x1 (hr 10), mode, inc x21 (min 20), mode -> single set_load pulse with 10/20; mode=3.
- Alarm hit and timeout: alarm 10:20, alarm_en=1, alarm_hit rises -> buzzer=1 next cycle. After 30 sec changes -> SNOOZE, alarm_hr:min=10:25, buzzer=0.
- Snooze wrap: snooze at 23:58 -> target 00:03. Fourth snooze attempt after 3 snoozes -> IDLE, alarm restored to 10:20.
- Stop priority: btn_stop and btn_snooze in the same cycle during RING -> IDLE, snooze count unchanged.
- Edit-mode suppression: alarm_hit rises while mode=2 -> no ring. Toggling btn_alarm off during SNOOZE -> IDLE, alarm_en=0.
